ram_stream_reader: RTL and testbench
====================================

RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 SHALL have parameter WIDTH_DATA, default 64: RAM word width and stream data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 11: RAM address width in bits.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: output buffer entries, fixed at 4.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port start, input, 1 bit: transfer request, sampled only in IDLE.
REQ-007 SHALL have port base_addr, input, ADDR_W bits: first RAM word address, sampled with start.
REQ-008 SHALL have port len, input, ADDR_W+1 bits: number of words to read (0..2^ADDR_W), sampled with start.
REQ-009 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port ram_addr, output, ADDR_W bits: address to the single-port RAM.
REQ-012 SHALL have port ram_wen, output, 1 bit: RAM write enable; tied to 0.
REQ-013 SHALL have port ram_rd_data, input, WIDTH_DATA bits: RAM read data, valid one cycle after its address.
REQ-014 SHALL have ports m_valid (output, 1), m_ready (input, 1), m_data (output, WIDTH_DATA) and m_last (output, 1): output stream.

Function
REQ-015 SHALL implement states IDLE, READ and DRAIN; transitions: IDLE->READ on start with len!=0; READ->DRAIN after the last read is issued; DRAIN->IDLE on the handshake of the final beat.
REQ-016 SHALL, for start with len==0 in IDLE, stay in IDLE, pulse done in the next cycle and emit no beats.
REQ-017 SHALL ignore start while busy.
REQ-018 SHALL, in READ, issue a read (advance ram_addr) in a cycle only if fifo_count + outstanding_reads < FIFO_DEPTH; outstanding_reads is 0 or 1.
REQ-019 SHALL compute ram_addr as base_addr plus the issue index, modulo 2^ADDR_W (wrap from all-ones to 0).
REQ-020 SHALL write ram_rd_data into the FIFO in the cycle after the corresponding issue.
REQ-021 SHALL hold ram_addr at its last value when not issuing; reads are non-destructive.
REQ-022 SHALL assert m_valid whenever the FIFO is non-empty, with m_data equal to the FIFO head.
REQ-023 SHALL complete a beat only when m_valid and m_ready are both high.
REQ-024 SHALL hold m_data and m_last stable while m_valid=1 and m_ready=0.
REQ-025 SHALL assert m_last only on beat number len (the final beat).
REQ-026 SHALL, with start sampled in cycle C0, drive ram_addr=base_addr in C1 and first assert m_valid in C3.
REQ-027 SHALL, with m_ready held high, deliver one beat per cycle (C3..C3+len-1) with no bubbles.
REQ-028 SHALL perform FIFO push and pop in the same cycle without loss; count is unchanged.
REQ-029 SHALL pulse done in the cycle after the final handshake, with busy=0 in that same cycle.
REQ-030 SHALL accept a new start in the cycle done is high.

Reset
REQ-031 SHALL, on rst_n low, immediately force state=IDLE, FIFO empty, and busy, done, m_valid, m_last, ram_addr, ram_wen all 0.
REQ-032 SHALL, on reset asserted mid-transfer, abort the transfer without pulsing done; no stale beats appear after reset is released.

Verification
REQ-033 SHALL cover: RAM[0x10..0x13]=A,B,C,D; base=0x10, len=4, m_ready=1 -> beats A,B,C,D in C3..C6, m_last in C6, done in C7.
REQ-034 SHALL cover: same transfer with m_ready toggling 1,0,0,1,... -> same data order, no drops or duplicates, m_data stable while stalled, FIFO never overflows.
REQ-035 SHALL cover: base=0x7FE, len=4 (ADDR_W=11) -> ram_addr sequence 0x7FE, 0x7FF, 0x000, 0x001.
REQ-036 SHALL cover: len=0 -> done pulse one cycle after start, m_valid stays 0, busy stays 0.
REQ-037 SHALL cover: a second start during busy -> ignored, and the first transfer's beat count is unchanged.
REQ-038 SHALL cover: rst_n low after beat 2 of len=8 -> outputs 0 asynchronously, no done; a new len=2 transfer afterwards delivers exactly 2 correct beats.

Source files
------------

// File: rtl/ram_stream_reader.sv
// Streams len consecutive words from a single-port synchronous-read RAM onto a
// valid/ready output stream through a small FIFO that absorbs downstream back-pressure.
module ram_stream_reader #(
  parameter int unsigned WIDTH_DATA = 64,
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W:0]       len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic                  ram_wen,
  input  logic [WIDTH_DATA-1:0] ram_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WIDTH_DATA-1:0] m_data,
  output logic                  m_last
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [ADDR_W:0] LenOne = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  state_e                state_q;
  logic [ADDR_W:0]       len_q;
  logic [ADDR_W:0]       issued_q;
  logic [ADDR_W:0]       beats_q;
  logic [ADDR_W-1:0]     ram_addr_q;
  logic                  addr_vld_q;
  logic                  rdv_q;
  logic                  done_q;

  logic [WIDTH_DATA-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q;
  logic [PtrW-1:0]       rd_ptr_q;
  logic [CntW-1:0]       count_q;

  logic                  push;
  logic                  pop;
  logic                  final_beat;
  logic [CntW-1:0]       occ;
  logic                  issue;

  always_comb begin
    push       = rdv_q;
    m_valid    = (count_q != '0);
    pop        = m_valid && m_ready;
    m_data     = fifo_mem_q[rd_ptr_q];
    final_beat = (beats_q == len_q - LenOne);
    m_last     = m_valid && final_beat;
    // Slots already claimed once this edge settles: stored, arriving now, and in flight.
    occ        = count_q + CntW'(rdv_q) + CntW'(addr_vld_q) - CntW'(pop);
    issue      = (state_q == StRead) && (issued_q != len_q) && (occ < CntW'(FIFO_DEPTH));
  end

  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign ram_addr = ram_addr_q;
  assign ram_wen  = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      len_q      <= '0;
      issued_q   <= '0;
      beats_q    <= '0;
      ram_addr_q <= '0;
      addr_vld_q <= 1'b0;
      rdv_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      rdv_q      <= addr_vld_q;
      addr_vld_q <= 1'b0;
      if (pop) begin
        beats_q <= beats_q + LenOne;
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (len == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q    <= StRead;
              len_q      <= len;
              ram_addr_q <= base_addr;
              addr_vld_q <= 1'b1;
              issued_q   <= LenOne;
              beats_q    <= '0;
            end
          end
        end
        StRead: begin
          if (issued_q == len_q) begin
            state_q <= StDrain;
          end else if (issue) begin
            ram_addr_q <= ram_addr_q + ADDR_W'(1);
            addr_vld_q <= 1'b1;
            issued_q   <= issued_q + LenOne;
          end
        end
        StDrain: begin
          if (pop && final_beat) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_mem_q[wr_ptr_q] <= ram_rd_data;
        wr_ptr_q             <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: a RAM model plus a reference built from the stream rules
// (beat i = RAM[(base+i) mod 2^ADDR_W], first beat 3 cycles after start, done after last).
module tb_ram_stream_reader;
  localparam int W     = 64;
  localparam int AW    = 11;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   len = '0;
  logic          busy, done, ram_wen, m_valid, m_last;
  logic          m_ready = 1'b1;
  logic [AW-1:0] ram_addr;
  logic [W-1:0]  ram_rd_data = '0;
  logic [W-1:0]  m_data;

  always #5 clk = ~clk;

  ram_stream_reader #(.WIDTH_DATA(W), .ADDR_W(AW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .ram_addr(ram_addr), .ram_wen(ram_wen),
    .ram_rd_data(ram_rd_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last)
  );

  logic [W-1:0] ram [DEPTH];
  always @(posedge clk) ram_rd_data <= ram[ram_addr];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Ready pattern: 0 = always high, 1 = 1,0,0 repeating, 2 = random.
  int ready_mode  = 0;
  int ready_phase = 0;
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       begin m_ready = (ready_phase % 3 == 0); ready_phase++; end
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor, sampled on the falling edge.
  int            cyc = 0;
  int            c0 = 0;
  bit            arm_c0 = 0;
  logic [W-1:0]  got_data [$];
  bit            got_last [$];
  int            got_cyc  [$];
  logic [AW-1:0] addr_q   [$];
  int            done_cnt = 0, done_cyc = 0, valid_cnt = 0;
  bit            busy_at_done = 0, prev_stall = 0, prev_done = 0, prev_last = 0;
  logic [W-1:0]  prev_data = '0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_stall = 0;
      prev_done  = 0;
    end else begin
      if (arm_c0 && start) begin c0 = cyc; arm_c0 = 0; end
      if (prev_stall) begin
        chk("stall_valid", 64'(m_valid), 64'd1);
        chk("stall_data", m_data, prev_data);
        chk("stall_last", 64'(m_last), 64'(prev_last));
      end
      if (m_valid) valid_cnt++;
      if (m_valid && m_ready) begin
        got_data.push_back(m_data);
        got_last.push_back(m_last);
        got_cyc.push_back(cyc);
      end
      if (busy) addr_q.push_back(ram_addr);
      if (done) begin
        if (prev_done) chk("done_one_cycle", 64'(prev_done), 64'd0);
        done_cnt++;
        done_cyc     = cyc;
        busy_at_done = busy;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      prev_done  = done;
    end
  end

  task automatic clear_logs();
    got_data.delete(); got_last.delete(); got_cyc.delete(); addr_q.delete();
    done_cnt = 0; valid_cnt = 0;
  endtask

  task automatic launch(input logic [AW-1:0] b, input logic [AW:0] l, input int mode);
    @(posedge clk); #1;
    clear_logs();
    ready_mode  = mode;
    ready_phase = 0;
    arm_c0      = 1;
    start = 1'b1; base_addr = b; len = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) @(posedge clk);
    chk("done_seen", 64'(done_cnt != 0), 64'd1);
    repeat (3) @(posedge clk);
  endtask

  task automatic check_xfer(input string tag, input logic [AW-1:0] b, input int l,
                            input bit timed);
    int n;
    chk($sformatf("%s_beats", tag), 64'(got_data.size()), 64'(l));
    n = (got_data.size() < l) ? got_data.size() : l;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_data%0d", tag, i), got_data[i], ram[(int'(b) + i) % DEPTH]);
      chk($sformatf("%s_last%0d", tag, i), 64'(got_last[i]), 64'(i == l - 1));
      if (timed) chk($sformatf("%s_cyc%0d", tag, i), 64'(got_cyc[i] - c0), 64'(3 + i));
    end
    chk($sformatf("%s_done_cnt", tag), 64'(done_cnt), 64'd1);
    chk($sformatf("%s_busy_at_done", tag), 64'(busy_at_done), 64'd0);
    if (timed) chk($sformatf("%s_done_cyc", tag), 64'(done_cyc - c0), 64'(3 + l));
  endtask

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   len;
    int            mode;
    bit            timed;
    int            exp_done_ofs;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [AW-1:0] dd [$];
    logic [AW-1:0] exp_addr [4];

    for (int i = 0; i < DEPTH; i++) ram[i] = {$urandom, $urandom};
    ram[16'h10] = 64'hAAAA_0000_0000_000A;
    ram[16'h11] = 64'hBBBB_0000_0000_000B;
    ram[16'h12] = 64'hCCCC_0000_0000_000C;
    ram[16'h13] = 64'hDDDD_0000_0000_000D;

    vecs[0] = '{11'h010, 12'd4,    0, 1'b1, 7};
    vecs[1] = '{11'h010, 12'd4,    1, 1'b0, 0};
    vecs[2] = '{11'h123, 12'd1,    0, 1'b1, 4};
    vecs[3] = '{11'h7F0, 12'd2048, 0, 1'b1, 2051};
    vecs[4] = '{11'h055, 12'd17,   2, 1'b0, 0};

    #3;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_valid", 64'(m_valid), 64'd0);
    chk("rst_last", 64'(m_last), 64'd0);
    chk("rst_addr", 64'(ram_addr), 64'd0);
    chk("rst_wen", 64'(ram_wen), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      launch(vecs[v].base, vecs[v].len, vecs[v].mode);
      wait_done(4 * int'(vecs[v].len) + 40);
      check_xfer($sformatf("vec%0d", v), vecs[v].base, int'(vecs[v].len), vecs[v].timed);
      if (vecs[v].timed)
        chk($sformatf("vec%0d_done_ofs", v), 64'(done_cyc - c0), 64'(vecs[v].exp_done_ofs));
    end

    // Address wrap at the top of the RAM.
    launch(11'h7FE, 12'd4, 0);
    wait_done(60);
    check_xfer("wrap", 11'h7FE, 4, 1'b1);
    foreach (addr_q[i]) if (dd.size() == 0 || dd[$] != addr_q[i]) dd.push_back(addr_q[i]);
    exp_addr = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
    chk("wrap_addr_count", 64'(dd.size()), 64'd4);
    for (int i = 0; i < 4 && i < dd.size(); i++)
      chk($sformatf("wrap_addr%0d", i), 64'(dd[i]), 64'(exp_addr[i]));

    // Zero-length request.
    launch(11'h020, 12'd0, 0);
    repeat (4) @(posedge clk);
    chk("len0_done_cnt", 64'(done_cnt), 64'd1);
    chk("len0_done_cyc", 64'(done_cyc - c0), 64'd1);
    chk("len0_valid_cycles", 64'(valid_cnt), 64'd0);
    chk("len0_busy_cycles", 64'(addr_q.size()), 64'd0);

    // Start while busy is ignored.
    launch(11'h100, 12'd6, 1);
    repeat (2) @(posedge clk); #1;
    start = 1'b1; base_addr = 11'h200; len = 12'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(80);
    repeat (5) @(posedge clk);
    check_xfer("busy_start", 11'h100, 6, 1'b0);
    chk("busy_start_idle", 64'(busy), 64'd0);

    // New start accepted in the done cycle.
    launch(11'h300, 12'd3, 0);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) break;
    end
    chk("b2b_done_high", 64'(done), 64'd1);
    clear_logs();
    arm_c0 = 1; start = 1'b1; base_addr = 11'h340; len = 12'd5;
    @(posedge clk); #1;
    start = 1'b0; done_cnt = 0;
    wait_done(60);
    check_xfer("b2b", 11'h340, 5, 1'b1);

    // Reset in the middle of a transfer.
    launch(11'h400, 12'd8, 0);
    for (int i = 0; i < 40 && got_data.size() < 2; i++) begin @(negedge clk); #1; end
    chk("mid_rst_two_beats", 64'(got_data.size() >= 2), 64'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_valid", 64'(m_valid), 64'd0);
    chk("mid_rst_last", 64'(m_last), 64'd0);
    chk("mid_rst_addr", 64'(ram_addr), 64'd0);
    chk("mid_rst_wen", 64'(ram_wen), 64'd0);
    done_cnt = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    chk("mid_rst_no_done", 64'(done_cnt), 64'd0);
    launch(11'h500, 12'd2, 0);
    wait_done(40);
    repeat (5) @(posedge clk);
    check_xfer("post_rst", 11'h500, 2, 1'b1);

    // Randomised transfers against the reference.
    for (int r = 0; r < 15; r++) begin
      logic [AW-1:0] b;
      int            l, m;
      b = AW'($urandom);
      l = $urandom_range(1, 40);
      m = $urandom_range(0, 2);
      launch(b, (AW+1)'(l), m);
      wait_done(4 * l + 40);
      check_xfer($sformatf("rnd%0d", r), b, l, m == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
